// File: rtl/event_pulse_arb.sv
// Round-robin arbiter that stretches single-cycle events from four channels
// into one shared pulse of HOLD cycles, separated by at least GAP+1 low cycles.
module event_pulse_arb #(
    parameter int unsigned HOLD = 2,
    parameter int unsigned GAP  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [3:0] i_req,
    output logic       o_pulse,
    output logic [1:0] o_id,
    output logic       o_busy,
    output logic [3:0] o_drop
);

    localparam int unsigned N_CH  = 4;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [N_CH-1:0]    pend_q,  pend_d;
    logic [ID_W-1:0]    ptr_q,   ptr_d;
    logic               pulse_q, pulse_d;
    logic [ID_W-1:0]    id_q,    id_d;
    logic               busy_q,  busy_d;
    logic [N_CH-1:0]    drop_q,  drop_d;

    logic [N_CH-1:0]    eff;
    logic               gnt_vld;
    logic [ID_W-1:0]    gnt_id;
    logic               grant;

    // Round-robin pick: first set bit of eff starting at ptr.
    always_comb begin
        logic [ID_W-1:0] idx;
        eff     = pend_q | i_req;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = ptr_q + ID_W'(k);
            if (!gnt_vld && eff[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    assign grant = (state_q == ST_IDLE) && i_en && gnt_vld;

    // Pending bits: a second event on an already pending channel is lost.
    always_comb begin
        pend_d = pend_q;
        drop_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant && (gnt_id == ID_W'(i))) begin
                pend_d[i] = pend_q[i] & i_req[i];
            end else if (i_req[i]) begin
                drop_d[i] = pend_q[i];
                pend_d[i] = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        pulse_d = pulse_q;
        id_d    = id_q;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(HOLD - 1);
                    ptr_d   = gnt_id + ID_W'(1);
                    pulse_d = 1'b1;
                    id_d    = gnt_id;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    pulse_d = 1'b0;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = CNT_W'(GAP - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                pulse_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ptr_q   <= '0;
            pulse_q <= 1'b0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            pulse_q <= pulse_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign o_pulse = pulse_q;
    assign o_id    = id_q;
    assign o_busy  = busy_q;
    assign o_drop  = drop_q;

endmodule

// File: doc/event_pulse_arb.md
EVENT_PULSE_ARB -- requirements
Module: event_pulse_arb

Interface
REQ-001 Parameter HOLD, default 2: number of cycles o_pulse stays high per grant; legal range 1..15.
REQ-002 Parameter GAP, default 1: minimum number of low cycles on o_pulse between consecutive grants; legal range 0..15.
REQ-003 Clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 i_en  input  1  grant enable; when low, no new grant starts.
REQ-006 i_req  input  4  per-channel single-cycle event pulses, channel i on bit i.
REQ-007 o_pulse  output  1  shared stretched event pulse, registered.
REQ-008 o_id  output  2  channel currently served, registered, valid while o_pulse=1.
REQ-009 o_busy  output  1  high when the state is not IDLE, registered.
REQ-010 o_drop  output  4  single-cycle flag per channel: event lost, registered.

Function
REQ-011 The block SHALL keep a pending bit per channel, pend[3:0].
- Definition: eff[i] = pend[i] | i_req[i].
REQ-012 The FSM SHALL have three states: IDLE, HOLD and GAP.
REQ-013 In IDLE with i_en=1 and eff!=0, the block SHALL grant one channel g at the edge and move to HOLD.
- Selection: the first set bit of eff searching ptr, ptr+1, ..., ptr+3, modulo 4.
REQ-014 On a grant edge, the block SHALL:
- set o_pulse=1 and o_id=g;
- clear pend[g];
- set ptr = (g+1) mod 4;
- load the hold counter with HOLD-1.
REQ-015 Latency: i_req[i] high in cycle t with the block idle and enabled SHALL produce o_pulse=1 in cycles t+1 .. t+HOLD.
REQ-016 In HOLD, the block SHALL decrement the counter each cycle. When the counter is 0 at an edge:
- drop o_pulse to 0;
- if GAP>0, go to GAP with the counter set to GAP-1;
- if GAP=0, go to IDLE.
REQ-017 In GAP, the block SHALL decrement the counter each cycle and go to IDLE at the edge where the counter is 0.
REQ-018 GAP=0 SHALL still include one IDLE cycle between grants, so o_pulse is low for at least 1 cycle between grants.
REQ-019 For a non-granted channel i with i_req[i]=1 and pend[i]=0, the block SHALL set pend[i].
REQ-020 For a non-granted channel i with i_req[i]=1 and pend[i]=1, the block SHALL:
- keep pend[i]=1;
- assert o_drop[i] for the next cycle.
REQ-021 If the granted channel g has pend[g]=1 and i_req[g]=1 on the grant edge, the pending event SHALL be served and the new event SHALL set pend[g]. No drop is flagged.
REQ-022 When i_en=0:
- an in-progress HOLD/GAP sequence SHALL complete normally;
- pend SHALL keep accumulating per REQ-019/020;
- no grant SHALL occur.
REQ-023 i_en rising SHALL allow a grant on the same edge if the state is IDLE.
REQ-024 o_busy SHALL be 1 exactly while the state is HOLD or GAP.
REQ-025 o_id SHALL hold its last value while o_pulse=0.
REQ-026 Simultaneous requests on all four channels in one cycle SHALL be served in round-robin order starting at ptr, one grant per HOLD+GAP+1 cycles.

Reset
REQ-027 While Reset=1, the block SHALL hold the following, asynchronously and independent of Clk:
- state=IDLE;
- pend=0, ptr=0, counter=0;
- o_pulse=0, o_id=0, o_busy=0, o_drop=0.
REQ-028 Reset asserted mid-HOLD SHALL force o_pulse=0 immediately and discard all pending events.
REQ-029 The first grant after reset deassertion SHALL search starting from channel 0.

Verification
REQ-030 Single event, defaults: i_req=0001 for 1 cycle at t -> o_pulse=1 and o_id=0 in t+1..t+2, o_busy=1 in t+1..t+3, o_busy=0 at t+4.
REQ-031 All channels, defaults: i_req=1111 for 1 cycle -> o_id sequence 0,1,2,3, each pulse 2 cycles wide with a 2-cycle low gap (GAP + IDLE), no o_drop.
REQ-032 Overflow: during the hold of ch0, i_req=0100 pulsed twice -> o_drop=0100 for 1 cycle after the second pulse, ch2 served exactly once.
REQ-033 Round-robin fairness: after serving ch3, i_req=1001 simultaneously -> ch0 granted first, then ch3.
REQ-034 Enable gating: i_en=0, i_req=0010 pulsed once -> no o_pulse and pend=0010; i_en=1 -> o_pulse with o_id=1 on the next edge.
REQ-035 Async reset: Reset=1 mid-HOLD with pend=1010 -> o_pulse=0 without a clock edge; after release, no pulses occur until a new i_req.
